blowfish_f_pipe: RTL and testbench
==================================

# blowfish_f_pipe

Pipelined, parametrised Blowfish F-function engine with on-chip writable S-boxes, valid/ready handshaking and a sideband tag. Computes F(x) = ((S1[a] + S2[b]) ^ S3[c]) + S4[d] mod 2^32, where a, b, c, d are x[31:24], x[23:16], x[15:8] and x[7:0]. It replaces the single-shot F module in the Blowfish round datapath. The key-schedule controller loads the S-boxes through the write port, and the round controller streams one F operand per cycle.

## Interface
- PIPE_STAGES, 2, latency in cycles from input acceptance to out_valid; legal values 2 or 3
- TAG_W, 4, width of the sideband tag carried alongside each operand; minimum 1
- clk  input  1  clock; all logic rising-edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operand present
- in_ready  output  1  operand accepted when in_valid && in_ready
- in  input  32  F operand x (left half of block)
- in_tag  input  TAG_W  sideband tag, returned unchanged with the result
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- FxL  output  32  F(x)
- out_tag  output  TAG_W  tag of the result
- sbox_we  input  1  S-box write strobe
- sbox_sel  input  2  target S-box: 0..3 selects S1..S4
- sbox_addr  input  8  S-box entry
- sbox_wdata  input  32  write data

## Operation
- Global advance enable: en = !out_valid || out_ready. The whole pipe holds when en = 0.
- in_ready = en && !sbox_we && !rst (plus && !sbox_re when readback is compiled in).
- Stage 1 (always present):
  - On acceptance, all four S-boxes are read synchronously at bytes a..d.
  - The valid bit and tag are registered.
- Stage 2 (PIPE_STAGES = 3 only):
  - Registers t = (S1[a] + S2[b]) ^ S3[c].
  - Forwards S4[d], the valid bit and the tag.
- Final stage: registers FxL = t + S4[d], out_tag and out_valid.
- Arithmetic: both additions are 32-bit modulo 2^32. Carry out is discarded.
- Pipeline bubbles: a stage whose valid bit is 0 is overwritten when en = 1, regardless of downstream state. Throughput is one result per cycle when out_ready is held at 1.
- S-box writes:
  - Take effect at the clk edge where sbox_we = 1, regardless of en.
  - No operand is accepted in that cycle.
  - In-flight operands already hold their read data, so writes never corrupt them.
  - Back-to-back writes are allowed, one per cycle.
- Ordering: results leave in acceptance order. Tags are never reordered.

## Timing
- Reset values:
  - in_ready = 0 during rst.
  - out_valid = 0, FxL = 0, out_tag = 0.
  - All stage valid bits = 0.
- S-box contents are not initialised and are unaffected by rst.
- Latency:
  - An operand accepted at edge N gives out_valid = 1 after edge N + PIPE_STAGES − 1 when never stalled.
  - In other words, with PIPE_STAGES = 2, FxL is visible in the cycle after the one following acceptance.
- Stall: while out_valid && !out_ready:
  - FxL, out_tag and out_valid hold stable.
  - No stage advances.
  - S-box read outputs are held because RAM read enable = en.
- Handshake rules:
  - out_valid, once high, stays high with stable data until out_ready.
  - in_ready may depend combinationally on out_ready and sbox_we.
- Simultaneous sbox_we and in_valid: the write wins and the operand waits. in_valid must stay asserted.
- Reset mid-operation: all in-flight operands are discarded, no results are emitted, and S-box data is retained.
- First acceptance is possible in the first cycle with rst = 0.

## Configuration
- BF_SBOX_RDBK_EN defined:
  - Adds ports sbox_re (input, 1), sbox_rsel (input, 2) and sbox_rdata (output, 32).
  - sbox_rdata returns S[sbox_rsel][sbox_addr] one cycle after sbox_re and holds until the next sbox_re.
  - sbox_re blocks in_ready in its cycle.
  - sbox_re and sbox_we in the same cycle: the write has priority and sbox_rdata is unchanged.
  - sbox_rdata resets to 0.
- BF_SBOX_RDBK_EN not defined: these ports are absent and there is no read-back logic.

## Structure
- Package blowfish_pkg holds:
  - BF_WORD_W = 32.
  - SBOX_DEPTH = 256.
  - SBOX_AW = 8.
  - The sbox_sel_t enum (S1..S4 = 0..3).
- Sub-module bf_sbox_ram: 256×32 synchronous RAM with one write port, one read port and a read enable. It is instantiated four times. The S-box read port is multiplexed between the operand bytes and read-back.

## Test plan
- Load Sn[i] = i << (8·(n−1)) for all n and i. Send x = 0x01020304 with tag 0x5 and out_ready = 1. Expect FxL = 0x04030201 and out_tag = 0x5 after PIPE_STAGES cycles.
- Wrap-around: set S1[0xFF] = 0xFFFFFFFF, S2[0x01] = 0x00000002, S3[0x00] = 0 and S4[0x00] = 0xFFFFFFFF. Send x = 0xFF010000. Expect FxL = 0x00000000.
- Streaming: send 8 consecutive operands with tags 0..7 and out_ready = 1. Expect 8 consecutive results in order, one per cycle, with no bubbles.
- Backpressure: hold out_ready = 0 for 5 cycles mid-stream. FxL and out_tag must stay stable, in_ready must be 0, and no operand may be lost or duplicated after release.
- Write contention: pulse sbox_we (S3[0x03] := 0xDEADBEEF) in the same cycle as in_valid. in_ready must be 0 that cycle. The operand is accepted next cycle and its result uses 0xDEADBEEF.
- Reset mid-stream: assert rst with 2 operands in flight. out_valid must be 0 next cycle and no stale result may appear. A following operand must still compute correctly with the preloaded S-boxes.

Source files
------------

// File: rtl/blowfish_f_pipe_pkg.sv
// blowfish_pkg: shared widths, S-box geometry and S-box selector enum for the F-function pipe.
package blowfish_pkg;
    localparam int BF_WORD_W  = 32;
    localparam int SBOX_DEPTH = 256;
    localparam int SBOX_AW    = 8;
    typedef enum logic [1:0] {S1 = 2'd0, S2 = 2'd1, S3 = 2'd2, S4 = 2'd3} sbox_sel_t;
endpackage

// File: rtl/blowfish_f_pipe_if.sv
// blowfish_f_pipe_if: operand/result handshake and S-box load bus of the F-function pipe.
// Read-back signals exist only when BF_SBOX_RDBK_EN is defined.
interface blowfish_f_pipe_if
    import blowfish_pkg::*;
#(
    parameter int TAG_W = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [BF_WORD_W-1:0] in;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [BF_WORD_W-1:0] FxL;
    logic [TAG_W-1:0]     out_tag;
    logic                 sbox_we;
    logic [1:0]           sbox_sel;
    logic [SBOX_AW-1:0]   sbox_addr;
    logic [BF_WORD_W-1:0] sbox_wdata;
`ifdef BF_SBOX_RDBK_EN
    logic                 sbox_re;
    logic [1:0]           sbox_rsel;
    logic [BF_WORD_W-1:0] sbox_rdata;
    modport master (
        output in_valid, in, in_tag, out_ready, sbox_we, sbox_sel, sbox_addr, sbox_wdata,
               sbox_re, sbox_rsel,
        input  in_ready, out_valid, FxL, out_tag, sbox_rdata
    );
    modport slave (
        input  in_valid, in, in_tag, out_ready, sbox_we, sbox_sel, sbox_addr, sbox_wdata,
               sbox_re, sbox_rsel,
        output in_ready, out_valid, FxL, out_tag, sbox_rdata
    );
`else
    modport master (
        output in_valid, in, in_tag, out_ready, sbox_we, sbox_sel, sbox_addr, sbox_wdata,
        input  in_ready, out_valid, FxL, out_tag
    );
    modport slave (
        input  in_valid, in, in_tag, out_ready, sbox_we, sbox_sel, sbox_addr, sbox_wdata,
        output in_ready, out_valid, FxL, out_tag
    );
`endif
endinterface

// File: rtl/blowfish_f_pipe_sbox_ram.sv
// bf_sbox_ram: 256x32 S-box RAM, one write port and one registered read port with read enable.
module bf_sbox_ram
    import blowfish_pkg::*;
(
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [SBOX_AW-1:0]   i_waddr,
    input  logic [BF_WORD_W-1:0] i_wdata,
    input  logic                 i_re,
    input  logic [SBOX_AW-1:0]   i_raddr,
    output logic [BF_WORD_W-1:0] o_rdata
);
    logic [BF_WORD_W-1:0] r_mem [SBOX_DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/blowfish_f_pipe.sv
// blowfish_f_pipe: pipelined Blowfish F(x) = ((S1[a]+S2[b])^S3[c])+S4[d] with writable S-boxes and tag.
// Defining BF_SBOX_RDBK_EN adds an S-box read-back port sharing the RAM read ports.
module blowfish_f_pipe
    import blowfish_pkg::*;
#(
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input logic              clk,
    input logic              rst,
    blowfish_f_pipe_if.slave bf
);
    logic                 w_en;
    logic                 w_adv;
    logic                 w_acc;
    logic                 w_v1;
    logic                 w_re;
    logic [BF_WORD_W-1:0] w_src;
    logic [3:0]           w_we;
    logic [SBOX_AW-1:0]   w_raddr [4];
    logic [BF_WORD_W-1:0] w_s [4];
    logic [BF_WORD_W-1:0] w_t;
    logic [BF_WORD_W-1:0] w_f;
    logic                 w_vf;
    logic [TAG_W-1:0]     w_tagf;
    logic                 r_v1;
    logic [TAG_W-1:0]     r_tag1;

    assign w_en  = !bf.out_valid || bf.out_ready;
    assign w_acc = bf.in_valid && bf.in_ready;
    assign w_t   = (w_s[0] + w_s[1]) ^ w_s[2];

`ifdef BF_SBOX_RDBK_EN
    logic                 w_rd;
    logic                 r_dirty;
    logic                 r_rd_fresh;
    logic [1:0]           r_rsel;
    logic [BF_WORD_W-1:0] r_rhold;
    logic [BF_WORD_W-1:0] r_x1;

    // A read-back during a stall clobbers stage-1 RAM data; r_dirty re-reads it from r_x1.
    assign w_rd          = bf.sbox_re && !bf.sbox_we;
    assign w_adv         = w_en && !r_dirty;
    assign w_v1          = r_v1 && !r_dirty;
    assign w_re          = w_en || w_rd || r_dirty;
    assign w_src         = r_dirty ? r_x1 : bf.in;
    assign bf.in_ready   = w_adv && !bf.sbox_we && !bf.sbox_re && !rst;
    assign bf.sbox_rdata = r_rd_fresh ? w_s[r_rsel] : r_rhold;

    always_ff @(posedge clk) begin
        if (w_adv) r_x1 <= bf.in;
        if (rst) begin
            r_dirty    <= 1'b0;
            r_rd_fresh <= 1'b0;
            r_rsel     <= 2'd0;
            r_rhold    <= '0;
        end else begin
            r_dirty    <= w_rd && r_v1 && !w_adv;
            r_rd_fresh <= w_rd;
            if (w_rd) r_rsel <= bf.sbox_rsel;
            if (r_rd_fresh) r_rhold <= w_s[r_rsel];
        end
    end
`else
    assign w_adv       = w_en;
    assign w_v1        = r_v1;
    assign w_re        = w_en;
    assign w_src       = bf.in;
    assign bf.in_ready = w_en && !bf.sbox_we && !rst;
`endif

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        assign w_we[i] = bf.sbox_we && (bf.sbox_sel == 2'(i));
`ifdef BF_SBOX_RDBK_EN
        assign w_raddr[i] = w_rd ? bf.sbox_addr : w_src[31-8*i -: 8];
`else
        assign w_raddr[i] = w_src[31-8*i -: 8];
`endif
        bf_sbox_ram u_ram (
            .clk     (clk),
            .i_we    (w_we[i]),
            .i_waddr (bf.sbox_addr),
            .i_wdata (bf.sbox_wdata),
            .i_re    (w_re),
            .i_raddr (w_raddr[i]),
            .o_rdata (w_s[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_tag1 <= '0;
        end else if (w_adv) begin
            r_v1   <= w_acc;
            r_tag1 <= bf.in_tag;
        end
    end

    if (PIPE_STAGES == 3) begin : g_s2
        logic                 r_v2;
        logic [TAG_W-1:0]     r_tag2;
        logic [BF_WORD_W-1:0] r_t;
        logic [BF_WORD_W-1:0] r_s4;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_v2   <= 1'b0;
                r_tag2 <= '0;
                r_t    <= '0;
                r_s4   <= '0;
            end else if (w_en) begin
                r_v2   <= w_v1;
                r_tag2 <= r_tag1;
                r_t    <= w_t;
                r_s4   <= w_s[3];
            end
        end
        assign w_f    = r_t + r_s4;
        assign w_vf   = r_v2;
        assign w_tagf = r_tag2;
    end else begin : g_s1
        assign w_f    = w_t + w_s[3];
        assign w_vf   = w_v1;
        assign w_tagf = r_tag1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bf.out_valid <= 1'b0;
            bf.FxL       <= '0;
            bf.out_tag   <= '0;
        end else if (w_en) begin
            bf.out_valid <= w_vf;
            bf.FxL       <= w_f;
            bf.out_tag   <= w_tagf;
        end
    end
endmodule

// File: tb/tb_blowfish_f_pipe.sv
// tb_blowfish_f_pipe: directed scoreboard bench for blowfish_f_pipe (PIPE_STAGES = 2, TAG_W = 4).
module tb_blowfish_f_pipe;
    import blowfish_pkg::*;
    localparam int PS = 2;

    typedef struct packed {
        logic [31:0] fx;
        logic [3:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    exp_t        q[$];
    int          out_cyc[$];
    int          cyc   = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    int          base;
    logic [31:0] sb [4][256];
    logic [31:0] fa;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    blowfish_f_pipe_if #(.TAG_W(4)) bf ();
    blowfish_f_pipe #(.PIPE_STAGES(PS), .TAG_W(4)) dut (.clk(clk), .rst(rst), .bf(bf));

    task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] f(logic [31:0] x);
        return ((sb[0][x[31:24]] + sb[1][x[23:16]]) ^ sb[2][x[15:8]]) + sb[3][x[7:0]];
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && bf.out_valid && bf.out_ready) begin
            chk("sb_pending", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                out_cyc.push_back(cyc);
                chk("FxL", bf.FxL, e.fx);
                chk("out_tag", 32'(bf.out_tag), 32'(e.tag));
            end
        end
    end

    task automatic wr(sbox_sel_t s, int a, logic [31:0] d);
        bf.sbox_we    = 1'b1;
        bf.sbox_sel   = s;
        bf.sbox_addr  = 8'(a);
        bf.sbox_wdata = d;
        @(posedge clk);
        #1;
        sb[s][a]   = d;
        bf.sbox_we = 1'b0;
    endtask

    task automatic send(logic [31:0] x, logic [3:0] t);
        bit   ok = 1'b0;
        exp_t e;
        bf.in_valid = 1'b1;
        bf.in       = x;
        bf.in_tag   = t;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (bf.in_ready) begin
                e.fx  = f(x);
                e.tag = t;
                q.push_back(e);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bf.in_valid = 1'b0;
        chk("accept", 32'(ok), 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && q.size() != 0; k++) @(posedge clk);
        #1;
        chk("drain_empty", 32'(q.size()), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        bf.in_valid = 1'b0; bf.in = '0; bf.in_tag = '0; bf.out_ready = 1'b1;
        bf.sbox_we = 1'b0; bf.sbox_sel = 2'd0; bf.sbox_addr = '0; bf.sbox_wdata = '0;
`ifdef BF_SBOX_RDBK_EN
        bf.sbox_re = 1'b0; bf.sbox_rsel = 2'd0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(bf.out_valid), 0);
        chk("rst_FxL", bf.FxL, 0);
        chk("rst_out_tag", 32'(bf.out_tag), 0);
        chk("rst_in_ready", 32'(bf.in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("first_in_ready", 32'(bf.in_ready), 1);
        @(posedge clk); #1;
        for (int n = 0; n < 4; n++)
            for (int i = 0; i < 256; i++) wr(sbox_sel_t'(n), i, 32'(i) << (8 * n));
        // identity-like tables
        send(32'h01020304, 4'h5);
        repeat (PS - 1) begin
            @(negedge clk);
            chk("lat_early", 32'(bf.out_valid), 0);
        end
        @(negedge clk);
        chk("lat_valid", 32'(bf.out_valid), 1);
        chk("basic_FxL", bf.FxL, 32'h04030201);
        chk("basic_tag", 32'(bf.out_tag), 5);
        @(posedge clk); #1;
        drain();
        // modular wrap of both additions
        wr(S1, 8'hFF, 32'hFFFFFFFF);
        wr(S2, 8'h01, 32'h00000002);
        wr(S3, 8'h00, 32'h00000000);
        wr(S4, 8'h00, 32'hFFFFFFFF);
        send(32'hFF010000, 4'h1);
        repeat (PS) @(negedge clk);
        chk("wrap_valid", 32'(bf.out_valid), 1);
        chk("wrap_FxL", bf.FxL, 32'h00000000);
        @(posedge clk); #1;
        drain();
        // streaming, one result per cycle
        base = out_cyc.size();
        for (int t = 0; t < 8; t++) send($urandom, 4'(t));
        drain();
        chk("stream_cnt", 32'(out_cyc.size() - base), 8);
        for (int k = 1; k < 8; k++)
            chk("no_bubble", 32'(out_cyc[base+k] - out_cyc[base+k-1]), 1);
        // backpressure
        fa = f(32'h0A0B0C0D);
        send(32'h0A0B0C0D, 4'h1);
        send(32'h10203040, 4'h2);
        bf.out_ready = 1'b0;
        bf.in_valid  = 1'b1;
        bf.in        = 32'h55AA33CC;
        bf.in_tag    = 4'h3;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 32'(bf.out_valid), 1);
            chk("bp_in_ready", 32'(bf.in_ready), 0);
            chk("bp_FxL", bf.FxL, fa);
            chk("bp_tag", 32'(bf.out_tag), 1);
            @(posedge clk); #1;
        end
        bf.out_ready = 1'b1;
        send(32'h55AA33CC, 4'h3);
        drain();
        // write contention: write wins, operand waits
        bf.sbox_we    = 1'b1;
        bf.sbox_sel   = S3;
        bf.sbox_addr  = 8'h03;
        bf.sbox_wdata = 32'hDEADBEEF;
        bf.in_valid   = 1'b1;
        bf.in         = 32'h01020304;
        bf.in_tag     = 4'h9;
        @(negedge clk);
        chk("wc_in_ready", 32'(bf.in_ready), 0);
        @(posedge clk); #1;
        sb[2][3]   = 32'hDEADBEEF;
        bf.sbox_we = 1'b0;
        send(32'h01020304, 4'h9);
        repeat (PS) @(negedge clk);
        chk("wc_FxL", bf.FxL, 32'hE2ADBCEE);
        @(posedge clk); #1;
        drain();
        // reset with two operands in flight
        bf.out_ready = 1'b0;
        send(32'h11223344, 4'hA);
        send(32'h55667788, 4'hB);
        rst = 1'b1;
        q.delete();
        @(posedge clk); #1;
        bf.out_ready = 1'b1;
        @(negedge clk);
        chk("mrst_out_valid", 32'(bf.out_valid), 0);
        chk("mrst_in_ready", 32'(bf.in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("mrst_no_stale", 32'(bf.out_valid), 0);
        end
        @(posedge clk); #1;
        send(32'h01020304, 4'hC);
        repeat (PS) @(negedge clk);
        chk("mrst_after_FxL", bf.FxL, 32'hE2ADBCEE);
        chk("mrst_after_tag", 32'(bf.out_tag), 12);
        @(posedge clk); #1;
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
